rxuart: RTL and testbench

//  8N1 UART receiver; consumes the serial stream a txuart-style transmitter produces.

---
 rtl/rxuart_pkg.sv | 23 ++
 rtl/baud_tick_gen.sv | 38 +++
 rtl/rxuart.sv | 132 +++++++++++++
 tb/tb_rxuart.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rxuart_pkg.sv
// Shared UART definitions: receiver states, oversampling constants and the
// default fractional baud increment/modulus (16 MHz clock, 115200 baud).
package rxuart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int          OVERSAMPLE   = 16;
  localparam logic [3:0]  VOTE_TICK    = 4'd9;
  localparam logic [3:0]  SAMP0_TICK   = VOTE_TICK - 4'd2;
  localparam logic [3:0]  SAMP1_TICK   = VOTE_TICK - 4'd1;
  localparam logic [3:0]  LAST_TICK    = 4'(OVERSAMPLE - 1);

  // 16 MHz * 72 / 625 = 1.8432 MHz = 16 x 115200
  localparam int          DEF_TICK_INC = 72;
  localparam int          DEF_TICK_MOD = 625;
  localparam int          DEF_ACC_W    = 10;

endpackage

// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator: adds TICK_INC each clock and emits a
// one-cycle tick whenever the sum reaches TICK_MOD, carrying the remainder.
module baud_tick_gen #(
  parameter int TICK_INC = 72,
  parameter int TICK_MOD = 625,
  parameter int ACC_W    = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam logic [ACC_W-1:0] INC_V = ACC_W'(TICK_INC);
  localparam logic [ACC_W-1:0] MOD_V = ACC_W'(TICK_MOD);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;
  logic             w_tick;

  // Sum fits in ACC_W bits because 2^ACC_W > TICK_MOD + TICK_INC.
  assign w_sum  = r_acc + INC_V;
  assign w_tick = (w_sum >= MOD_V);
  assign o_tick = w_tick;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (w_tick) begin
      r_acc <= w_sum - MOD_V;
    end else begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/rxuart.sv
// 8N1 UART receiver: 2-FF synchroniser, 16x fractional oversampling,
// 2-of-3 majority vote per bit, single-cycle data/frame-error strobes.
module rxuart
  import rxuart_pkg::*;
#(
  parameter int TICK_INC = DEF_TICK_INC,
  parameter int TICK_MOD = DEF_TICK_MOD,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  logic [1:0] r_sync;
  state_t     r_state,  w_state_next;
  logic       r_armed,  w_armed_next;
  logic [3:0] r_tcnt,   w_tcnt_next;
  logic [2:0] r_idx,    w_idx_next;
  logic [7:0] r_shift,  w_shift_next;
  logic [7:0] r_data,   w_data_next;
  logic       r_valid,  w_valid_next;
  logic       r_ferr,   w_ferr_next;
  logic       r_s0, r_s1;

  logic w_rx_s, w_tick, w_start, w_vote, w_vote_tick, w_end_tick;

  assign w_rx_s      = r_sync[1];
  assign w_start     = (r_state == IDLE) && r_armed && !w_rx_s;
  assign w_vote      = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);
  assign w_vote_tick = w_tick && (r_tcnt == VOTE_TICK);
  assign w_end_tick  = w_tick && (r_tcnt == LAST_TICK);

  // Clearing on the start edge phase-aligns the bit grid to the falling edge.
  baud_tick_gen #(
    .TICK_INC (TICK_INC),
    .TICK_MOD (TICK_MOD),
    .ACC_W    (ACC_W)
  ) u_baud (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_start),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync  <= 2'b11;
      r_state <= IDLE;
      r_armed <= 1'b0;
      r_tcnt  <= 4'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_s0    <= 1'b1;
      r_s1    <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], i_uart_rx};
      r_state <= w_state_next;
      r_armed <= w_armed_next;
      r_tcnt  <= w_tcnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_ferr  <= w_ferr_next;
      if (w_tick && r_tcnt == SAMP0_TICK) r_s0 <= w_rx_s;
      if (w_tick && r_tcnt == SAMP1_TICK) r_s1 <= w_rx_s;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_armed_next = r_armed;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_data_next  = r_data;
    w_valid_next = 1'b0;
    w_ferr_next  = 1'b0;
    w_tcnt_next  = r_tcnt;
    if (w_start)     w_tcnt_next = 4'd0;
    else if (w_tick) w_tcnt_next = r_tcnt + 4'd1;

    case (r_state)
      IDLE: begin
        if (w_rx_s)  w_armed_next = 1'b1;
        if (w_start) w_state_next = START;
      end
      START: begin
        if (w_vote_tick && w_vote) begin
          w_state_next = IDLE;
        end else if (w_end_tick) begin
          w_state_next = DATA;
          w_idx_next   = 3'd0;
        end
      end
      DATA: begin
        if (w_vote_tick) w_shift_next = {w_vote, r_shift[7:1]};
        if (w_end_tick) begin
          if (r_idx == 3'd7) w_state_next = STOP;
          else               w_idx_next   = r_idx + 3'd1;
        end
      end
      STOP: begin
        // Leave at mid-stop so a following start edge is never missed.
        if (w_vote_tick) begin
          if (w_vote) begin
            w_valid_next = 1'b1;
            w_data_next  = r_shift;
          end else begin
            w_ferr_next  = 1'b1;
          end
          w_state_next = IDLE;
          w_armed_next = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rxuart.sv
// Directed bench for rxuart: behavioural 8N1 transmitter drives the line,
// a monitor collects strobes and received bytes for comparison.
`timescale 1ns/1ps
module tb_rxuart;

  localparam real BIT_NS = 1.0e9 / 115200.0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_busy;

  int vectors    = 0;
  int miscompares = 0;
  int nvalid = 0, nerr = 0, nboth = 0;
  logic [7:0] rxq[$];

  always #31.25 clk = ~clk;

  rxuart dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_uart_rx   (rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) begin
        nvalid++;
        rxq.push_back(o_data);
      end
      if (o_frame_err) nerr++;
      if (o_valid && o_frame_err) nboth++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input real scale);
    rx = 1'b0;
    #(BIT_NS * scale);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_NS * scale);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    #(BIT_NS * scale);
  endtask

  task automatic idle_bits(input real n);
    rx = 1'b1;
    #(BIT_NS * n);
  endtask

  task automatic check_queue(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_count"}, rxq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < rxq.size()) chk($sformatf("%s_byte%0d", tag, i), rxq[i], exp[i]);
    end
    rxq.delete();
  endtask

  initial begin
    string       msg;
    logic [7:0]  exp_q[$];
    int          v0, e0;
    real         scales[2];

    // Reset state
    #200;
    chk("rst_data",  o_data, 8'h00);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ferr",  o_frame_err, 1'b0);
    chk("rst_busy",  o_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single byte after long idle
    idle_bits(20);
    send_byte(8'h48, 1'b0, 1.0);
    idle_bits(2);
    chk("t1_nvalid", nvalid, 1);
    chk("t1_data",   o_data, 8'h48);
    chk("t1_nerr",   nerr, 0);
    exp_q = '{8'h48};
    check_queue("t1", exp_q);

    // 2: back-to-back string
    msg = "Hello, world! ";
    exp_q.delete();
    for (int i = 0; i < msg.len(); i++) begin
      send_byte(msg[i], 1'b0, 1.0);
      exp_q.push_back(msg[i]);
    end
    idle_bits(2);
    chk("t2_nvalid", nvalid, 15);
    chk("t2_nerr",   nerr, 0);
    check_queue("t2", exp_q);

    // 3: 40-clock glitch on idle line
    rx = 1'b0;
    #(40 * 62.5);
    rx = 1'b1;
    #(90 * 62.5);
    chk("t3_busy_clear", o_busy, 1'b0);
    idle_bits(2);
    chk("t3_nvalid", nvalid, 15);
    chk("t3_nerr",   nerr, 0);

    // 4: framing error then break, then recovery
    send_byte(8'h55, 1'b1, 1.0);
    rx = 1'b0;
    #(BIT_NS * 20);
    chk("t4_nerr",   nerr, 1);
    chk("t4_nvalid", nvalid, 15);
    chk("t4_data",   o_data, 8'h20);
    idle_bits(2);
    send_byte(8'hA3, 1'b0, 1.0);
    idle_bits(2);
    chk("t4_nerr_after", nerr, 1);
    exp_q = '{8'hA3};
    check_queue("t4", exp_q);
    chk("t4_data_a3", o_data, 8'hA3);

    // 5: asynchronous reset mid-frame
    fork
      send_byte(8'hF0, 1'b0, 1.0);
      begin
        #(BIT_NS * 5.5);
        rst = 1'b1;
        #1;
        chk("t5_rst_data",  o_data, 8'h00);
        chk("t5_rst_busy",  o_busy, 1'b0);
        chk("t5_rst_valid", o_valid, 1'b0);
        chk("t5_rst_ferr",  o_frame_err, 1'b0);
        #(10 * 62.5);
        rst = 1'b0;
      end
    join
    idle_bits(2);
    chk("t5_nvalid_none", nvalid, 16);
    send_byte(8'h0F, 1'b0, 1.0);
    idle_bits(2);
    exp_q = '{8'h0F};
    check_queue("t5", exp_q);
    chk("t5_nerr", nerr, 1);

    // 6: +/-3% transmitter baud error, back-to-back random bytes
    scales[0] = 1.03;
    scales[1] = 0.97;
    for (int s = 0; s < 2; s++) begin
      v0 = nvalid;
      e0 = nerr;
      exp_q.delete();
      for (int i = 0; i < 10; i++) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        send_byte(b, 1'b0, scales[s]);
      end
      idle_bits(2);
      chk($sformatf("t6_s%0d_nvalid", s), nvalid - v0, 10);
      chk($sformatf("t6_s%0d_nerr", s), nerr - e0, 0);
      check_queue($sformatf("t6_s%0d", s), exp_q);
    end

    chk("never_both", nboth, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
